onehot_scan_decoder: RTL and testbench
======================================

// Module: onehot_scan_decoder
// PURPOSE
//  Registered, parametrised N-to-2^N one-hot decoder with enable and two modes:
//  direct decode of a select input, or autonomous scan walking the one-hot output
//  0..2^SEL_W-1 with programmable dwell. Drives digit/row strobes (7-seg, LED matrix).
// PARAMETERS
//  SEL_W  2   select width; N = 1<<SEL_W outputs; legal 1..6
//  DIV_W  16  dwell counter width
// PORTS
//  clk    in  1      clock, all state on rising edge
//  rst_n  in  1      asynchronous, active-low reset
//  en     in  1      0: outputs blanked; 1: active
//  mode   in  1      0: direct decode, 1: scan
//  x      in  SEL_W  select for direct mode
//  dwell  in  DIV_W  cycles per scan step minus 1
//  y      out N      registered one-hot (or all-zero) strobes
//  idx    out SEL_W  index currently driven on y
//  step   out 1      1-cycle pulse when scan idx advances
//  wrap   out 1      1-cycle pulse when scan idx goes N-1 -> 0 (coincides with step)
// BEHAVIOUR
//  - Reset (async assert, sync release): y=0, idx=0, step=0, wrap=0, cnt=0, state IDLE.
//  - FSM states IDLE, DIRECT, SCAN (+ BLANK if macro set); next state from en/mode each cycle.
//  - IDLE (en=0): y=0 and cnt=0 next cycle; idx holds; step=wrap=0.
//  - DIRECT (en=1,mode=0): y <= 1<<x, idx <= x; latency 1 cycle; x tracked every cycle.
//  - SCAN entry (from IDLE or DIRECT): idx<=0, y<=1, cnt<=0, no step pulse.
//  - SCAN: cnt++ each cycle; when cnt>=dwell: cnt<=0, idx<=(idx+1) mod N, y<=1<<idx_next,
//    step=1; wrap=1 iff old idx==N-1. Use >= so lowering dwell mid-step never misses.
//  - dwell=0: advance every cycle. Step period = dwell+1 cycles.
//  - dwell sampled live; change takes effect on the current step.
//  - Mode change while en=1: enter new state with its entry action next cycle.
//  - en drop mid-scan: y=0 next cycle; re-enable always restarts scan at idx 0.
//  - y is always one-hot or all-zero; never multi-hot, including across mode switches.
//  - cnt saturates logically via compare; no overflow since cnt<=dwell<=2^DIV_W-1.
// CONFIGURATION
//  SCAN_BLANK_EN defined: on each scan advance insert one BLANK cycle (y=0, idx already
//   updated, step/wrap pulse in that cycle), then y=1<<idx and cnt restarts; period
//   dwell+2. Anti-ghosting for multiplexed displays. en=0 or mode=0 in BLANK exits normally.
//  SCAN_BLANK_EN undefined: no BLANK state; y switches directly; period dwell+1.
// STRUCTURE
//  Shared package decode_pkg: state encodings (ST_IDLE, ST_DIRECT, ST_SCAN, ST_BLANK),
//   onehot(SEL_W) function / constant N derivation.
//  Sub-module scan_dwell_counter (DIV_W): cnt, clear, terminal flag cnt>=dwell.
//  Top: FSM, idx register, y/step/wrap registers.
// TESTING
//  1 Reset: assert rst_n=0 mid-scan between edges -> y=0, idx=0, step=wrap=0 immediately.
//  2 Direct SEL_W=2: en=1,mode=0,x=2 -> y=0100 next edge; x=3 -> 1000; en=0 -> 0000 next edge.
//  3 Scan dwell=3: y=0001 x4 cyc, 0010 x4, 0100 x4, 1000 x4, 0001; wrap with 1000->0001 only.
//  4 dwell=0: y advances every cycle; with SCAN_BLANK_EN y=0001,0000,0010,0000,0100...
//  5 Mid-scan (idx=2) mode->0,x=3 -> y=1000 next edge; mode->1 -> y=0001, idx=0 restart.
//  6 SEL_W=3,dwell=1: 8 steps of 2 cycles, one wrap per 16 cycles; dwell 5->0 mid-step
//    with cnt=3 -> advance next edge.

Source files
------------

// File: rtl/decode_pkg.sv
// State encodings and decode helpers shared by the one-hot scan decoder.
// onehot() is sized for the widest legal select; callers truncate to their N.
package decode_pkg;

  localparam int MAX_SEL_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2,
    ST_BLANK  = 2'd3
  } state_t;

  function automatic int num_out(input int sel_w);
    return 1 << sel_w;
  endfunction

  function automatic logic [63:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    return 64'd1 << sel;
  endfunction

endpackage

// File: rtl/scan_dwell_counter.sv
// Dwell counter for the scan step: counts up each cycle, restarts on clear or terminal.
// Terminal is combinational on the current count, so a live dwell change applies at once.
module scan_dwell_counter #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] dwell,
  output logic             term
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // >= rather than == so lowering dwell below the running count still ends the step
  assign term = (cnt_q >= dwell);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clr || term) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered one-hot decoder with direct and auto-scan modes; all outputs 1 cycle after inputs.
// Define SCAN_BLANK_EN to insert one all-zero BLANK cycle on every scan advance.
module onehot_scan_decoder
  import decode_pkg::*;
#(
  parameter  int SEL_W = 2,
  parameter  int DIV_W = 16,
  localparam int N     = num_out(SEL_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] x,
  input  logic [DIV_W-1:0] dwell,
  output logic [N-1:0]     y,
  output logic [SEL_W-1:0] idx,
  output logic             step,
  output logic             wrap
);

  state_t           state_q, state_d;
  logic [N-1:0]     y_q, y_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             cnt_clr;
  logic             term;
  logic [SEL_W-1:0] idx_inc;

  assign idx_inc = idx_q + SEL_W'(1);

  scan_dwell_counter #(
    .DIV_W (DIV_W)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .dwell (dwell),
    .term  (term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    if (en) begin
      if (!mode) begin
        state_d = ST_DIRECT;
      end else begin
        case (state_q)
`ifdef SCAN_BLANK_EN
          ST_SCAN: state_d = term ? ST_BLANK : ST_SCAN;
`else
          ST_SCAN: state_d = ST_SCAN;
`endif
          default: state_d = ST_SCAN;
        endcase
      end
    end
  end

  // Outputs are computed for the state being entered and registered alongside it
  always_comb begin
    y_d     = '0;
    idx_d   = idx_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    cnt_clr = 1'b1;
    case (state_d)
      ST_DIRECT: begin
        y_d   = N'(onehot(MAX_SEL_W'(x)));
        idx_d = x;
      end
      ST_SCAN: begin
        if (state_q == ST_SCAN) begin
          cnt_clr = 1'b0;
          if (term) begin
            idx_d  = idx_inc;
            y_d    = N'(onehot(MAX_SEL_W'(idx_inc)));
            step_d = 1'b1;
            wrap_d = &idx_q;
          end else begin
            y_d = y_q;
          end
        end else if (state_q == ST_BLANK) begin
          y_d = N'(onehot(MAX_SEL_W'(idx_q)));
        end else begin
          idx_d = '0;
          y_d   = N'(1);
        end
      end
`ifdef SCAN_BLANK_EN
      ST_BLANK: begin
        idx_d  = idx_inc;
        step_d = 1'b1;
        wrap_d = &idx_q;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      idx_q  <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      idx_q  <= idx_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed bench for onehot_scan_decoder: SEL_W=2 and SEL_W=3 instances share controls.
module tb_onehot_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n, en, mode;
  logic [1:0]  x2;
  logic [2:0]  x3;
  logic [15:0] dwell;
  logic [3:0]  y2;
  logic [1:0]  idx2;
  logic        step2, wrap2;
  logic [7:0]  y3;
  logic [2:0]  idx3;
  logic        step3, wrap3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_scan_decoder #(.SEL_W(2), .DIV_W(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .x(x2), .dwell(dwell),
    .y(y2), .idx(idx2), .step(step2), .wrap(wrap2)
  );

  onehot_scan_decoder #(.SEL_W(3), .DIV_W(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .x(x3), .dwell(dwell),
    .y(y3), .idx(idx3), .step(step3), .wrap(wrap3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1);
  end

  initial begin
    logic [3:0] t3 [17];
    logic [3:0] t4 [5];
    int nstep;
    int nwrap;
    t3 = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4, 4'h4,
           4'h8, 4'h8, 4'h8, 4'h8, 4'h1};
`ifdef SCAN_BLANK_EN
    t4 = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4};
`else
    t4 = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
`endif

    rst_n = 1'b0; en = 1'b0; mode = 1'b0; x2 = '0; x3 = '0; dwell = '0;
    repeat (2) tick();
    chk("rst_y", y2, 0);
    chk("rst_idx", idx2, 0);
    chk("rst_step", step2, 0);
    chk("rst_wrap", wrap2, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_y", y2, 0);

    // direct decode
    en = 1'b1; mode = 1'b0; x2 = 2'd2;
    tick();
    chk("dir_x2_y", y2, 4'b0100);
    chk("dir_x2_idx", idx2, 2);
    x2 = 2'd3;
    tick();
    chk("dir_x3_y", y2, 4'b1000);
    chk("dir_x3_idx", idx2, 3);
    en = 1'b0;
    tick();
    chk("dir_off_y", y2, 0);
    chk("dir_off_idx", idx2, 3);
    chk("dir_off_step", step2, 0);

    // scan with dwell=3: four cycles per digit, wrap only on 1000 -> 0001
    dwell = 16'd3; en = 1'b1; mode = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      tick();
      chk($sformatf("scan3_y_c%0d", c), y2, t3[c]);
      chk($sformatf("scan3_step_c%0d", c), step2, (c != 0 && c % 4 == 0));
      chk($sformatf("scan3_wrap_c%0d", c), wrap2, (c == 16));
    end

    // dwell=0: advance every cycle
    en = 1'b0;
    tick();
    dwell = 16'd0; en = 1'b1; mode = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("scan0_y_c%0d", c), y2, t4[c]);
    end

    // mode switch mid-scan
    dwell = 16'd3; en = 1'b0;
    tick();
    en = 1'b1; mode = 1'b1;
    tick();
    repeat (8) tick();
    chk("mid_pre_y", y2, 4'b0100);
    chk("mid_pre_idx", idx2, 2);
    mode = 1'b0; x2 = 2'd3;
    tick();
    chk("mid_dir_y", y2, 4'b1000);
    chk("mid_dir_idx", idx2, 3);
    mode = 1'b1;
    tick();
    chk("mid_rescan_y", y2, 4'b0001);
    chk("mid_rescan_idx", idx2, 0);
    chk("mid_rescan_step", step2, 0);

    // async reset between edges while stepping every cycle
    dwell = 16'd0;
    repeat (2) tick();
    chk("pre_rst_step", step2, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_y", y2, 0);
    chk("arst_idx", idx2, 0);
    chk("arst_step", step2, 0);
    chk("arst_wrap", wrap2, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_y", y2, 4'b0001);

    // SEL_W=3, dwell=1: 16 steps and 2 wraps in 32 cycles
    en = 1'b0;
    tick();
    dwell = 16'd1; en = 1'b1; mode = 1'b1;
    tick();
    chk("s3_entry_y", y3, 8'h01);
    nstep = 0;
    nwrap = 0;
    for (int c = 1; c <= 32; c++) begin
      tick();
      chk($sformatf("s3_y_c%0d", c), y3, 64'(1) << ((c / 2) % 8));
      nstep += int'(step3);
      nwrap += int'(wrap3);
    end
    chk("s3_steps", nstep, 16);
    chk("s3_wraps", nwrap, 2);

    // lower dwell below running count: advance on the next edge
    dwell = 16'd5; en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    repeat (3) tick();
    chk("dw_pre_y", y3, 8'h01);
    dwell = 16'd0;
    tick();
    chk("dw_post_y", y3, 8'h02);
    chk("dw_post_idx", idx3, 1);
    chk("dw_post_step", step3, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
